// File: rtl/unidade_controle_if.sv
// Control-unit <-> datapath bundle.
//   master: unidade_controle (consumes instr/zero, drives every control line)
//   slave : datapath side (instruction memory, register bank, ULA, PC logic)
// Signals: instr/zero in; instr_reg, ra/rb/rw, we_reg, we_mem, sel_din_reg,
// soma_ou_subtrai, subtraindo, imediato, sel_imediato, pc_we, pc_fonte,
// instr_concluida, erro, estado out.
interface unidade_controle_if;
  logic [31:0] instr;
  logic        zero;
  logic [31:0] instr_reg;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [4:0]  rw;
  logic        we_reg;
  logic        we_mem;
  logic [1:0]  sel_din_reg;
  logic        soma_ou_subtrai;
  logic        subtraindo;
  logic        imediato;
  logic [1:0]  sel_imediato;
  logic        pc_we;
  logic [1:0]  pc_fonte;
  logic        instr_concluida;
  logic        erro;
  logic [2:0]  estado;

  modport master (
    input  instr, zero,
    output instr_reg, ra, rb, rw, we_reg, we_mem, sel_din_reg,
           soma_ou_subtrai, subtraindo, imediato, sel_imediato,
           pc_we, pc_fonte, instr_concluida, erro, estado
  );

  modport slave (
    output instr, zero,
    input  instr_reg, ra, rb, rw, we_reg, we_mem, sel_din_reg,
           soma_ou_subtrai, subtraindo, imediato, sel_imediato,
           pc_we, pc_fonte, instr_concluida, erro, estado
  );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control unit for the RV64I datapath.
// Fetches one instruction into instr_reg, decodes it and sequences register
// bank, data memory, ULA and PC controls through BUSCA/DECOD/EXEC/MEM/WB.
// Unsupported encodings park the FSM in ERRO until reset.
// Ports: clk, rst_n (async active-low), bus (unidade_controle_if.master).
module unidade_controle #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic               clk,
  input logic               rst_n,
  unidade_controle_if.master bus
);

  typedef enum logic [2:0] {
    BUSCA = 3'd0,
    DECOD = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    ERRO  = 3'd5
  } estado_t;

  typedef enum logic [3:0] {
    OP_LD, OP_SD, OP_ADD, OP_SUB, OP_ADDI,
    OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_ILEGAL
  } op_t;

  estado_t     estado_q, estado_d;
  logic [31:0] instr_reg_q, instr_reg_d;

  op_t        op;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  // ULA controls for the decoded instruction, reused in EXEC, MEM and WB
  logic       ula_soma, ula_sub, ula_imm;
  logic [1:0] ula_sel_imm;

  assign opcode = instr_reg_q[6:0];
  assign funct3 = instr_reg_q[14:12];
  assign funct7 = instr_reg_q[31:25];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= BUSCA;
      instr_reg_q <= NOP_INSTR;
    end else begin
      estado_q    <= estado_d;
      instr_reg_q <= instr_reg_d;
    end
  end

  always_comb begin
    op = OP_ILEGAL;
    case (opcode)
      7'b0000011: if (funct3 == 3'b011) op = OP_LD;
      7'b0100011: if (funct3 == 3'b011) op = OP_SD;
      7'b0110011: if (funct3 == 3'b000) begin
        if (funct7 == 7'b0000000)      op = OP_ADD;
        else if (funct7 == 7'b0100000) op = OP_SUB;
      end
      7'b0010011: if (funct3 == 3'b000) op = OP_ADDI;
      7'b0010111: op = OP_AUIPC;
      7'b1101111: op = OP_JAL;
      7'b1100111: if (funct3 == 3'b000) op = OP_JALR;
      7'b1100011: if (funct3 == 3'b000) op = OP_BEQ;
      default:    op = OP_ILEGAL;
    endcase
  end

  always_comb begin
    ula_soma    = 1'b0;
    ula_sub     = 1'b0;
    ula_imm     = 1'b0;
    ula_sel_imm = 2'b00;
    case (op)
      OP_ADD:                  ula_soma = 1'b1;
      OP_SUB, OP_BEQ:          ula_sub  = 1'b1;
      OP_ADDI, OP_LD, OP_JALR: ula_imm  = 1'b1;
      OP_SD: begin
        ula_imm     = 1'b1;
        ula_sel_imm = 2'b01;
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    estado_d    = estado_q;
    instr_reg_d = instr_reg_q;
    case (estado_q)
      BUSCA: begin
        instr_reg_d = bus.instr;
        estado_d    = DECOD;
      end
      DECOD: estado_d = (op == OP_ILEGAL) ? ERRO : EXEC;
      EXEC: begin
        if (op == OP_BEQ)                     estado_d = BUSCA;
        else if (op == OP_LD || op == OP_SD)  estado_d = MEM;
        else                                  estado_d = WB;
      end
      MEM:     estado_d = (op == OP_LD) ? WB : BUSCA;
      WB:      estado_d = BUSCA;
      ERRO:    estado_d = ERRO;
      default: estado_d = BUSCA;
    endcase
  end

  // Output logic. ULA controls stay applied from EXEC through WB so the
  // ULA result (address or write-back value) is stable while consumed.
  always_comb begin
    bus.we_reg          = 1'b0;
    bus.we_mem          = 1'b0;
    bus.sel_din_reg     = 2'b00;
    bus.soma_ou_subtrai = 1'b0;
    bus.subtraindo      = 1'b0;
    bus.imediato        = 1'b0;
    bus.sel_imediato    = 2'b00;
    bus.pc_we           = 1'b0;
    bus.pc_fonte        = 2'b00;
    bus.erro            = 1'b0;
    case (estado_q)
      EXEC, MEM, WB: begin
        bus.soma_ou_subtrai = ula_soma;
        bus.subtraindo      = ula_sub;
        bus.imediato        = ula_imm;
        bus.sel_imediato    = ula_sel_imm;
        if (estado_q == EXEC && op == OP_BEQ) begin
          bus.pc_we    = 1'b1;
          bus.pc_fonte = bus.zero ? 2'b01 : 2'b00;
        end
        if (estado_q == MEM && op == OP_SD) begin
          bus.we_mem = 1'b1;
          bus.pc_we  = 1'b1;
        end
        if (estado_q == WB) begin
          // x0 is never written, but the instruction still retires
          bus.we_reg = (instr_reg_q[11:7] != 5'd0);
          bus.pc_we  = 1'b1;
          case (op)
            OP_LD:    bus.sel_din_reg = 2'b01;
            OP_AUIPC: bus.sel_din_reg = 2'b11;
            OP_JAL: begin
              bus.sel_din_reg  = 2'b10;
              bus.pc_fonte     = 2'b01;
              bus.sel_imediato = 2'b11;
            end
            OP_JALR: begin
              bus.sel_din_reg = 2'b10;
              bus.pc_fonte    = 2'b10;
            end
            default: ;
          endcase
        end
      end
      ERRO:    bus.erro = 1'b1;
      default: ;
    endcase
  end

  assign bus.instr_concluida = bus.pc_we;
  assign bus.instr_reg       = instr_reg_q;
  assign bus.ra              = instr_reg_q[19:15];
  assign bus.rb              = instr_reg_q[24:20];
  assign bus.rw              = instr_reg_q[11:7];
  assign bus.estado          = estado_q;

endmodule
